// File: rtl/sonar_sweep_sequencer.sv
// Sonar sweep control FSM: position servo, settle, measure, transmit, advance angle.
// Define SONAR_SWEEP_PINGPONG_EN for a back-and-forth sweep; default wraps NPOS-1 -> 0.
module sonar_sweep_sequencer #(
   parameter int unsigned NPOS           = 8,
   parameter int unsigned POS_W          = 3,
   parameter int unsigned SETTLE_CYCLES  = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 1500000,
   parameter int unsigned CNT_W          = 21
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ligar,
   input  logic             tick,
   input  logic             med_pronto,
   input  logic             tx_pronto,
   output logic             medir,
   output logic             transmitir,
   output logic             erro_medida,
   output logic [POS_W-1:0] sel_posicao,
   output logic             fim_posicao,
   output logic             ocupado,
   output logic [3:0]       db_estado
);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      ESPERA_TICK = 4'h1,
      POSICIONA   = 4'h2,
      DISPARA     = 4'h3,
      ESPERA_MED  = 4'h4,
      TRANSMITE   = 4'h5,
      ESPERA_TX   = 4'h6,
      PROXIMA     = 4'h7,
      FIM         = 4'hF
   } state_e;

   localparam logic [POS_W-1:0] POS_LAST     = POS_W'(NPOS - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   // Timeout is measured from the medir cycle, so ESPERA_MED itself lasts TIMEOUT_CYCLES-1 cycles.
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               erro_q, erro_d;
   logic               pend_q, pend_d;
   logic               medir_q, transmitir_q, fim_q, ocupado_q;
   logic               busy_c;
`ifdef SONAR_SWEEP_PINGPONG_EN
   logic               dir_up_q, dir_up_d;
`endif

   assign busy_c = !(state_q inside {INICIAL, ESPERA_TICK});

   // Next-state, counter, position and flag logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pos_d    = pos_q;
      erro_d   = erro_q;
      pend_d   = pend_q;
`ifdef SONAR_SWEEP_PINGPONG_EN
      dir_up_d = dir_up_q;
`endif
      if (tick && busy_c) pend_d = 1'b1;

      case (state_q)
         INICIAL: begin
            if (ligar) begin
               pos_d    = '0;
`ifdef SONAR_SWEEP_PINGPONG_EN
               dir_up_d = 1'b1;
`endif
               state_d  = ESPERA_TICK;
            end
         end
         ESPERA_TICK: begin
            if (!ligar) begin
               state_d = INICIAL;
            end else if (tick || pend_q) begin
               pend_d  = 1'b0;
               cnt_d   = '0;
               state_d = POSICIONA;
            end
         end
         POSICIONA: begin
            if (cnt_q == SETTLE_LAST) state_d = DISPARA;
            else                      cnt_d   = cnt_q + CNT_W'(1);
         end
         DISPARA: begin
            cnt_d   = '0;
            state_d = ESPERA_MED;
         end
         ESPERA_MED: begin
            if (med_pronto) begin
               erro_d  = 1'b0;
               state_d = TRANSMITE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               erro_d  = 1'b1;
               state_d = TRANSMITE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         TRANSMITE: state_d = ESPERA_TX;
         ESPERA_TX: begin
            if (tx_pronto) begin
               erro_d  = 1'b0;
               state_d = PROXIMA;
            end
         end
         PROXIMA: begin
`ifdef SONAR_SWEEP_PINGPONG_EN
            if (dir_up_q) begin
               if (pos_q == POS_LAST) begin
                  dir_up_d = 1'b0;
                  pos_d    = pos_q - POS_W'(1);
               end else begin
                  pos_d    = pos_q + POS_W'(1);
               end
            end else begin
               if (pos_q == '0) begin
                  dir_up_d = 1'b1;
                  pos_d    = pos_q + POS_W'(1);
               end else begin
                  pos_d    = pos_q - POS_W'(1);
               end
            end
`else
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
`endif
            state_d = ligar ? ESPERA_TICK : FIM;
         end
         FIM: begin
            pend_d  = 1'b0;
            state_d = INICIAL;
         end
         default: state_d = INICIAL;
      endcase
   end

   // State and registered outputs; pulses are decoded from the next state so they align with it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= INICIAL;
         cnt_q        <= '0;
         pos_q        <= '0;
         erro_q       <= 1'b0;
         pend_q       <= 1'b0;
         medir_q      <= 1'b0;
         transmitir_q <= 1'b0;
         fim_q        <= 1'b0;
         ocupado_q    <= 1'b0;
`ifdef SONAR_SWEEP_PINGPONG_EN
         dir_up_q     <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pos_q        <= pos_d;
         erro_q       <= erro_d;
         pend_q       <= pend_d;
         medir_q      <= (state_d == DISPARA);
         transmitir_q <= (state_d == TRANSMITE);
         fim_q        <= (state_d == PROXIMA);
         ocupado_q    <= !(state_d inside {INICIAL, ESPERA_TICK});
`ifdef SONAR_SWEEP_PINGPONG_EN
         dir_up_q     <= dir_up_d;
`endif
      end
   end

   assign medir       = medir_q;
   assign transmitir  = transmitir_q;
   assign erro_medida = erro_q;
   assign sel_posicao = pos_q;
   assign fim_posicao = fim_q;
   assign ocupado     = ocupado_q;
   assign db_estado   = state_q;

endmodule

// File: tb/tb_sonar_sweep_sequencer.sv
// Scoreboard bench for sonar_sweep_sequencer: directed cycles push expected medir/transmitir/fim events.
module tb_sonar_sweep_sequencer;

   localparam int unsigned NPOS = 4, POS_W = 2, SETTLE = 4, TIMEOUT = 50, CNT_W = 8;

   logic clock = 1'b0, reset = 1'b1, ligar = 1'b0, tick = 1'b0;
   logic med_pronto = 1'b0, tx_pronto = 1'b0;
   logic medir, transmitir, erro_medida, fim_posicao, ocupado;
   logic [POS_W-1:0] sel_posicao;
   logic [3:0] db_estado;

   sonar_sweep_sequencer #(
      .NPOS(NPOS), .POS_W(POS_W), .SETTLE_CYCLES(SETTLE),
      .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset), .ligar(ligar), .tick(tick),
      .med_pronto(med_pronto), .tx_pronto(tx_pronto),
      .medir(medir), .transmitir(transmitir), .erro_medida(erro_medida),
      .sel_posicao(sel_posicao), .fim_posicao(fim_posicao),
      .ocupado(ocupado), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // kind: 0 medir (lat from POSICIONA entry), 1 transmitir (lat from medir), 2 fim (lat from transmitir)
   typedef struct {int kind; int pos; int erro; int lat;} exp_t;
   exp_t sb_q[$];
   int n_checks = 0, n_errors = 0;
   int model_pos = 0;
   bit model_up = 1'b1;
`ifdef SONAR_SWEEP_PINGPONG_EN
   int seq[9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
`else
   int seq[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_medir"}, 32'(medir), 0);
      chk({name, "_transmitir"}, 32'(transmitir), 0);
      chk({name, "_erro"}, 32'(erro_medida), 0);
      chk({name, "_fim"}, 32'(fim_posicao), 0);
      chk({name, "_ocupado"}, 32'(ocupado), 0);
      chk({name, "_sel"}, 32'(sel_posicao), 0);
      chk({name, "_db"}, 32'(db_estado), 0);
   endtask

   // Monitor: pops one expected event per output pulse.
   int cyc = 0, posi_cyc = 0, medir_cyc = 0, tx_cyc = 0;
   logic [3:0] prev_st = 4'h0;
   always @(negedge clock) begin : monitor
      int kind, lat;
      exp_t e;
      cyc++;
      if (db_estado == 4'h2 && prev_st != 4'h2) posi_cyc = cyc;
      prev_st = db_estado;
      if (!reset && (medir || transmitir || fim_posicao)) begin
         if (medir) begin
            kind = 0; lat = cyc - posi_cyc; medir_cyc = cyc;
         end else if (transmitir) begin
            kind = 1; lat = cyc - medir_cyc; tx_cyc = cyc;
         end else begin
            kind = 2; lat = cyc - tx_cyc;
         end
         n_checks++;
         if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, nothing expected", kind, cyc);
         end else begin
            e = sb_q.pop_front();
            if (kind != e.kind || sel_posicao !== POS_W'(e.pos) ||
                erro_medida !== 1'(e.erro) || lat != e.lat) begin
               n_errors++;
               $display("FAIL event: got kind=%0d pos=%0d erro=%0b lat=%0d, expected kind=%0d pos=%0d erro=%0d lat=%0d",
                        kind, sel_posicao, erro_medida, lat, e.kind, e.pos, e.erro, e.lat);
            end
         end
      end
   end

   task automatic wait_evt(input int kind, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if ((kind == 0 && medir === 1'b1) || (kind == 1 && transmitir === 1'b1) ||
             (kind == 2 && fim_posicao === 1'b1)) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL wait_timeout: event kind %0d not seen within %0d cycles", kind, budget);
   endtask

   task automatic advance_model();
`ifdef SONAR_SWEEP_PINGPONG_EN
      if (model_up) begin
         if (model_pos == int'(NPOS) - 1) begin model_up = 1'b0; model_pos--; end
         else model_pos++;
      end else begin
         if (model_pos == 0) begin model_up = 1'b1; model_pos++; end
         else model_pos--;
      end
`else
      model_pos = (model_pos + 1) % int'(NPOS);
`endif
   endtask

   // One measurement cycle. med_d < 0: no med_pronto (timeout). extra: ticks during ESPERA_MED.
   task automatic run_cycle(input int pos, input int med_d, input int tx_d, input int extra,
                            input bit send_tick, input bit drop_ligar);
      int erro, txlat, wait_n;
      erro   = (med_d < 0) ? 1 : 0;
      txlat  = (med_d < 0) ? int'(TIMEOUT) : med_d + 1;
      wait_n = (med_d < 0) ? int'(TIMEOUT) - 1 : med_d;
      sb_q.push_back('{0, pos, 0, int'(SETTLE)});
      sb_q.push_back('{1, pos, erro, txlat});
      sb_q.push_back('{2, pos, 0, tx_d + 1});
      if (send_tick) begin
         @(negedge clock); tick = 1'b1;
         @(negedge clock); tick = 1'b0;
      end
      wait_evt(0, 20);
      for (int i = 1; i <= wait_n; i++) begin
         @(negedge clock);
         med_pronto = (i == med_d);
         tick       = (i % 2 == 0) && (i <= 2 * extra);
      end
      @(negedge clock);
      med_pronto = 1'b0;
      tick       = 1'b0;
      if (transmitir !== 1'b1) wait_evt(1, 60);
      for (int i = 1; i <= tx_d; i++) begin
         @(negedge clock);
         tx_pronto = (i == tx_d);
         if (drop_ligar && i == 1) ligar = 1'b0;
      end
      @(negedge clock);
      tx_pronto = 1'b0;
      if (fim_posicao !== 1'b1) wait_evt(2, 40);
      advance_model();
   endtask

   initial begin
      #1;
      chk_reset_outputs("reset");
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      @(negedge clock); ligar = 1'b1;
      @(negedge clock); @(negedge clock);
      chk("idle_db", 32'(db_estado), 1);
      chk("idle_ocupado", 32'(ocupado), 0);

      // Basic cycle, then timeout cycle.
      run_cycle(0, 10, 20, 0, 1'b1, 1'b0);
      @(negedge clock);
      chk("t1_sel", 32'(sel_posicao), 1);
      chk("t1_db", 32'(db_estado), 1);
      run_cycle(1, -1, 20, 0, 1'b1, 1'b0);
      @(negedge clock);
      chk("t2_sel", 32'(sel_posicao), 2);

      // Sweep sequence over the remaining positions.
      for (int k = 2; k < 8; k++) begin
         run_cycle(seq[k], 3, 2, 0, 1'b1, 1'b0);
         @(negedge clock);
         chk("sweep_sel", 32'(sel_posicao), 32'(seq[k+1]));
      end

      // Three ticks during ESPERA_MED: exactly one queued cycle.
      run_cycle(model_pos, 10, 5, 3, 1'b1, 1'b0);
      @(negedge clock);
      chk("pend_gap_db", 32'(db_estado), 1);
      @(negedge clock);
      chk("pend_start_db", 32'(db_estado), 2);
      run_cycle(model_pos, 3, 2, 0, 1'b0, 1'b0);
      repeat (30) @(negedge clock);
      chk("no_third_db", 32'(db_estado), 1);
      chk("no_third_ocupado", 32'(ocupado), 0);

      // ligar dropped during ESPERA_TX.
      run_cycle(model_pos, 3, 10, 0, 1'b1, 1'b1);
      @(negedge clock);
      chk("stop_fim_db", 32'(db_estado), 15);
      chk("stop_fim_ocupado", 32'(ocupado), 1);
      @(negedge clock);
      chk("stop_ini_db", 32'(db_estado), 0);
      chk("stop_ini_ocupado", 32'(ocupado), 0);
      repeat (3) @(negedge clock);
      chk("stop_hold_db", 32'(db_estado), 0);
      chk("stop_hold_sel", 32'(sel_posicao), 32'(model_pos));
      ligar = 1'b1;
      model_pos = 0;
      model_up  = 1'b1;
      @(negedge clock); @(negedge clock);
      chk("restart_sel", 32'(sel_posicao), 0);
      chk("restart_db", 32'(db_estado), 1);
      run_cycle(0, 3, 2, 0, 1'b1, 1'b0);
      @(negedge clock);

      // Async reset in ESPERA_MED.
      sb_q.push_back('{0, 1, 0, int'(SETTLE)});
      @(negedge clock); tick = 1'b1;
      @(negedge clock); tick = 1'b0;
      wait_evt(0, 20);
      repeat (5) @(negedge clock);
      chk("pre_reset_db", 32'(db_estado), 4);
      #2 reset = 1'b1;
      #1 chk_reset_outputs("async_reset");
      sb_q.delete();
      @(negedge clock); reset = 1'b0;
      model_pos = 0;
      model_up  = 1'b1;
      @(negedge clock); @(negedge clock);
      chk("post_reset_db", 32'(db_estado), 1);

      // med_pronto coinciding with the timeout: no error.
      run_cycle(0, int'(TIMEOUT) - 1, 2, 0, 1'b1, 1'b0);
      repeat (5) @(negedge clock);
      chk("scoreboard_empty", 32'(sb_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
